peripheral_bfm_slave_bb: RTL and testbench

- AXI responder (slave) BFM that terminates the write-address, write-data, write-response, read-address and read-data channels driven by the MPSoC master BFM.
- Backs all accesses with an internal word-addressed memory and supports FIXED and INCR bursts of up to 16 beats.
- Returns OKAY or SLVERR responses. Used in DMA/MPSoC testbenches as the memory-side endpoint.

---
 rtl/peripheral_bfm_slave_bb.sv | 257 +++++++++++++++++++++++++
 tb/tb_peripheral_bfm_slave_bb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bfm_slave_bb.sv
// AXI responder BFM: word-addressed memory behind independent write and read FSMs.
// FIXED/INCR bursts up to 16 beats; illegal size/type or out-of-range beats return SLVERR.
module peripheral_bfm_slave_bb #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awadr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && ({32'd0, addr - BASE_ADDR} < (64'(DEPTH) << 2));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  wstate_e     wstate_q, wstate_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]  bid_q, bid_d, awid_q, awid_d, wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] waddr_q, waddr_d;
  logic        wincr_q, wincr_d, wlegal_q, wlegal_d, werr_q, werr_d;
  logic        mem_we, w_beat_ok, w_last_exp, w_err_now;

  rstate_e     rstate_q, rstate_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d, rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, raddr_q, raddr_d, r_load_addr;
  logic        rincr_q, rincr_d, rlegal_q, rlegal_d, r_load, r_load_legal, r_ok;

  always_comb begin
    wstate_d   = wstate_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    awid_d     = awid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    wincr_d    = wincr_q;
    wlegal_d   = wlegal_q;
    werr_d     = werr_q;
    mem_we     = 1'b0;
    w_beat_ok  = wlegal_q && in_range(waddr_q);
    w_last_exp = (wcnt_q == wlen_q);
    w_err_now  = !w_beat_ok || (wid != awid_q) || (wlast != w_last_exp);
    unique case (wstate_q)
      WIdle: if (awvalid && awready_q) begin
        awid_d    = awid;
        waddr_d   = awadr;
        wlen_d    = awlen;
        wincr_d   = (awburst == 2'b01);
        wlegal_d  = (awsize == 3'b010) && !awburst[1];
        werr_d    = 1'b0;
        wcnt_d    = 4'd0;
        awready_d = 1'b0;
        wready_d  = 1'b1;
        wstate_d  = WData;
      end
      WData: if (wvalid && wready_q) begin
        mem_we  = w_beat_ok;
        werr_d  = werr_q | w_err_now;
        wcnt_d  = wcnt_q + 4'd1;
        waddr_d = wincr_q ? waddr_q + 32'd4 : waddr_q;
        // Beat counter, not wlast, decides when the burst ends.
        if (w_last_exp) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bid_d    = awid_q;
          bresp_d  = (werr_q || w_err_now) ? 2'b10 : 2'b00;
          wstate_d = WResp;
        end
      end
      WResp: if (bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wstate_d  = WIdle;
      end
      default: wstate_d = WIdle;
    endcase
  end

  always_comb begin
    rstate_d     = rstate_q;
    arready_d    = arready_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rid_d        = rid_q;
    rlen_d       = rlen_q;
    rcnt_d       = rcnt_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    raddr_d      = raddr_q;
    rincr_d      = rincr_q;
    rlegal_d     = rlegal_q;
    r_load       = 1'b0;
    r_load_addr  = raddr_q;
    r_load_legal = rlegal_q;
    unique case (rstate_q)
      RIdle: if (arvalid && arready_q) begin
        rid_d        = arid;
        rlen_d       = arlen;
        rincr_d      = (arburst == 2'b01);
        rlegal_d     = (arsize == 3'b010) && !arburst[1];
        rcnt_d       = 4'd0;
        raddr_d      = araddr;
        arready_d    = 1'b0;
        rvalid_d     = 1'b1;
        rlast_d      = (arlen == 4'd0);
        r_load       = 1'b1;
        r_load_addr  = araddr;
        r_load_legal = (arsize == 3'b010) && !arburst[1];
        rstate_d     = RData;
      end
      RData: if (rvalid_q && rready) begin
        if (rcnt_q == rlen_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          rstate_d  = RIdle;
        end else begin
          rcnt_d      = rcnt_q + 4'd1;
          raddr_d     = rincr_q ? raddr_q + 32'd4 : raddr_q;
          rlast_d     = ((rcnt_q + 4'd1) == rlen_q);
          r_load      = 1'b1;
          r_load_addr = rincr_q ? raddr_q + 32'd4 : raddr_q;
        end
      end
      default: rstate_d = RIdle;
    endcase
    r_ok = r_load_legal && in_range(r_load_addr);
    if (r_load) begin
      rdata_d = r_ok ? mem[word_idx(r_load_addr)] : 32'd0;
      rresp_d = r_ok ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate_q  <= WIdle;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'b00;
      awid_q    <= 4'd0;
      waddr_q   <= 32'd0;
      wlen_q    <= 4'd0;
      wcnt_q    <= 4'd0;
      wincr_q   <= 1'b0;
      wlegal_q  <= 1'b0;
      werr_q    <= 1'b0;
      rstate_q  <= RIdle;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= 4'd0;
      rlen_q    <= 4'd0;
      rcnt_q    <= 4'd0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'd0;
      raddr_q   <= 32'd0;
      rincr_q   <= 1'b0;
      rlegal_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wincr_q   <= wincr_d;
      wlegal_q  <= wlegal_d;
      werr_q    <= werr_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rincr_q   <= rincr_d;
      rlegal_q  <= rlegal_d;
    end
  end

  // Memory has no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (mem_we && aresetn) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx(waddr_q)][8*i +: 8] <= wrdata[8*i +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_peripheral_bfm_slave_bb.sv
// Directed self-checking bench for peripheral_bfm_slave_bb (DEPTH=1024, BASE_ADDR=0).
module tb_peripheral_bfm_slave_bb;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid, awlen, wid, bid, arid, arlen, rid;
  logic [31:0] awadr, wrdata, araddr, rdata;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  peripheral_bfm_slave_bb dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    awid = id; awadr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    chk("awready_idle", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    chk("awready_busy", 32'(awready), 32'd0);
    chk("wready_open", 32'(wready), 32'd1);
  endtask

  task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    wid = id; wrdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(input logic [3:0] id, input logic [1:0] resp);
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 32'(resp));
    chk("wready_closed", 32'(wready), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
  endtask

  task automatic wr_fill(input logic [31:0] addr, input logic [31:0] base, input int n);
    aw_req(4'd0, addr, 4'(n - 1), 3'b010, 2'b01);
    for (int i = 0; i < n; i++) w_beat(4'd0, base + 32'(i), 4'hF, i == n - 1);
    b_take(4'd0, 2'b00);
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("arready_busy", 32'(arready), 32'd0);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rid", 32'(rid), 32'(id));
    chk("rdata", rdata, data);
    chk("rresp", 32'(rresp), 32'(resp));
    chk("rlast", 32'(rlast), 32'(last));
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic r_done();
    chk("rvalid_clear", 32'(rvalid), 32'd0);
    chk("rlast_clear", 32'(rlast), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  task automatic rd1(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    ar_req(4'd0, addr, 4'd0, 3'b010, 2'b01);
    r_beat(4'd0, data, resp, 1'b1);
    r_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    aresetn = 1'b0;
    awid = 0; awadr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wid = 0; wrdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    tick();
    tick();
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_ids", {24'd0, bid, rid}, 32'd0);
    chk("rst_resps", {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    tick();

    // Single write then read back
    aw_req(4'd3, 32'h10, 4'd0, 3'b010, 2'b01);
    w_beat(4'd3, 32'hDEAD_BEEF, 4'hF, 1'b1);
    b_take(4'd3, 2'b00);
    ar_req(4'd5, 32'h10, 4'd0, 3'b010, 2'b01);
    r_beat(4'd5, 32'hDEAD_BEEF, 2'b00, 1'b1);
    r_done();

    // INCR burst with partial strobes over known prior contents
    wr_fill(32'h100, 32'hA5A5_0000, 4);
    aw_req(4'd1, 32'h100, 4'd3, 3'b010, 2'b01);
    w_beat(4'd1, 32'd1, 4'hF, 1'b0);
    w_beat(4'd1, 32'd2, 4'h3, 1'b0);
    w_beat(4'd1, 32'd3, 4'hF, 1'b0);
    w_beat(4'd1, 32'd4, 4'h3, 1'b1);
    b_take(4'd1, 2'b00);
    ar_req(4'd2, 32'h100, 4'd3, 3'b010, 2'b01);
    r_beat(4'd2, 32'd1, 2'b00, 1'b0);
    r_beat(4'd2, 32'hA5A5_0002, 2'b00, 1'b0);
    r_beat(4'd2, 32'd3, 2'b00, 1'b0);
    r_beat(4'd2, 32'hA5A5_0004, 2'b00, 1'b1);
    r_done();

    // 8-beat read with rready pattern 1,0,0,1
    wr_fill(32'h200, 32'h200, 8);
    ar_req(4'd9, 32'h200, 4'd7, 3'b010, 2'b01);
    beats = 0;
    for (int cyc = 0; cyc < 64 && beats < 8; cyc++) begin
      rready = (cyc % 4 == 0) || (cyc % 4 == 3);
      chk("bp_rvalid", 32'(rvalid), 32'd1);
      chk("bp_rdata", rdata, 32'h200 + 32'(beats));
      chk("bp_rlast", 32'(rlast), 32'(beats == 7));
      chk("bp_arready", 32'(arready), 32'd0);
      if (rready) beats++;
      tick();
    end
    rready = 1'b0;
    chk("bp_beats", 32'(beats), 32'd8);
    r_done();

    // Out-of-range write must not alias onto word 0
    wr_fill(32'h0, 32'h1111_1111, 1);
    aw_req(4'd0, 32'h1000, 4'd0, 3'b010, 2'b01);
    w_beat(4'd0, 32'hBAD0_BAD0, 4'hF, 1'b1);
    b_take(4'd0, 2'b10);
    rd1(32'h0, 32'h1111_1111, 2'b00);
    rd1(32'h1000, 32'd0, 2'b10);

    // Illegal size
    wr_fill(32'h30, 32'h3030_3030, 1);
    aw_req(4'd0, 32'h30, 4'd0, 3'b001, 2'b01);
    w_beat(4'd0, 32'h0000_0BAD, 4'hF, 1'b1);
    b_take(4'd0, 2'b10);
    rd1(32'h30, 32'h3030_3030, 2'b00);

    // Early wlast: all four beats still consumed
    aw_req(4'd4, 32'h40, 4'd3, 3'b010, 2'b01);
    w_beat(4'd4, 32'd0, 4'hF, 1'b0);
    w_beat(4'd4, 32'd1, 4'hF, 1'b1);
    chk("early_wready", 32'(wready), 32'd1);
    chk("early_bvalid", 32'(bvalid), 32'd0);
    w_beat(4'd4, 32'd2, 4'hF, 1'b0);
    chk("early_wready3", 32'(wready), 32'd1);
    chk("early_bvalid3", 32'(bvalid), 32'd0);
    w_beat(4'd4, 32'd3, 4'hF, 1'b1);
    b_take(4'd4, 2'b10);

    // Read loaded on the same edge as a write to that word sees old data
    wr_fill(32'h20, 32'h5, 1);
    aw_req(4'd6, 32'h20, 4'd0, 3'b010, 2'b01);
    wid = 4'd6; wrdata = 32'h77; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd7; araddr = 32'h20; arlen = 4'd0; arsize = 3'b010; arburst = 2'b01;
    arvalid = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("conc_bvalid", 32'(bvalid), 32'd1);
    r_beat(4'd7, 32'h5, 2'b00, 1'b1);
    r_done();
    b_take(4'd6, 2'b00);
    rd1(32'h20, 32'h77, 2'b00);

    // Reset mid-burst keeps the beats already written
    aw_req(4'd0, 32'h300, 4'd3, 3'b010, 2'b01);
    w_beat(4'd0, 32'h31, 4'hF, 1'b0);
    w_beat(4'd0, 32'h32, 4'hF, 1'b0);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_awready", 32'(awready), 32'd1);
    chk("mid_rst_wready", 32'(wready), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    aresetn = 1'b1;
    tick();
    ar_req(4'd0, 32'h300, 4'd1, 3'b010, 2'b01);
    r_beat(4'd0, 32'h31, 2'b00, 1'b0);
    r_beat(4'd0, 32'h32, 2'b00, 1'b1);
    r_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
